tt_sweep_checker: RTL

Parametrised exhaustive truth-table sweeper/checker for small combinational blocks. It drives every input vector 0..2^N_IN−1 onto a DUT, waits a programmable settle time, and samples the DUT response. It compares each response against a truth table supplied as a parameter, counts mismatches and records the first failure. The block sits beside the combinational exercise circuits as synthesizable self-test: one instance per DUT, controlled by a start/done handshake, with optional continuous re-sweep.

---
 rtl/tt_sweep_pkg.sv | 36 +++
 rtl/tt_sweep_checker_if.sv | 35 +++
 rtl/tt_err_tracker.sv | 55 +++++
 rtl/tt_sweep_checker.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// tt_sweep_pkg : state encoding and truth-table lookup for tt_sweep_checker
// Revision     : 1.0
// ============================================================================
package tt_sweep_pkg;

  localparam int TBL_AW    = 12;
  localparam int MAX_TBL_W = 1 << TBL_AW;
  localparam int MAX_OUT_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Returns entry vec of a table packed as N_OUT-bit slices, zero-extended.
  function automatic logic [MAX_OUT_W-1:0] exp_resp(
    input logic [MAX_TBL_W-1:0] tbl,
    input int unsigned          vec,
    input int unsigned          n_out
  );
    logic [MAX_OUT_W-1:0] r;
    int unsigned          pos;
    r = '0;
    for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
      pos = vec * n_out + i;
      if (i < n_out && pos < MAX_TBL_W) r[i[4:0]] = tbl[pos[TBL_AW-1:0]];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// tt_sweep_checker_if : control handshake, DUT stimulus/response and results
// Revision            : 1.0
// ============================================================================
interface tt_sweep_checker_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int ERR_W = 8
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic [N_IN-1:0]  stim_o;
  logic [N_OUT-1:0] resp_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [N_IN-1:0]  fail_vec;
  logic [N_OUT-1:0] fail_resp;
  logic [15:0]      sweep_cnt;

  modport master (
    input  start, continuous, abort, resp_i,
    output stim_o, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_resp, sweep_cnt
  );

  modport slave (
    output start, continuous, abort, resp_i,
    input  stim_o, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_resp, sweep_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tt_err_tracker.sv
`default_nettype none
// ============================================================================
// tt_err_tracker : saturating mismatch counter with first-failure capture
// Revision       : 1.0
// ============================================================================
module tt_err_tracker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int ERR_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr_i,
  input  wire logic             cmp_en_i,
  input  wire logic             mismatch_i,
  input  wire logic [N_IN-1:0]  vec_i,
  input  wire logic [N_OUT-1:0] resp_i,
  output logic      [ERR_W-1:0] err_cnt_o,
  output logic                  fail_valid_o,
  output logic      [N_IN-1:0]  fail_vec_o,
  output logic      [N_OUT-1:0] fail_resp_o
);

  logic [ERR_W-1:0] err_q;
  logic             fail_valid_q;
  logic [N_IN-1:0]  fail_vec_q;
  logic [N_OUT-1:0] fail_resp_q;

  // Clearing leaves fail_vec/fail_resp untouched; fail_valid qualifies them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_resp_q  <= '0;
    end else if (clr_i) begin
      err_q        <= '0;
      fail_valid_q <= 1'b0;
    end else if (cmp_en_i && mismatch_i) begin
      if (err_q != '1) err_q <= err_q + ERR_W'(1);
      if (!fail_valid_q) begin
        fail_valid_q <= 1'b1;
        fail_vec_q   <= vec_i;
        fail_resp_q  <= resp_i;
      end
    end
  end

  assign err_cnt_o    = err_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_vec_o   = fail_vec_q;
  assign fail_resp_o  = fail_resp_q;

endmodule
`default_nettype wire

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// tt_sweep_checker : exhaustive truth-table sweep of a combinational DUT
// Revision         : 1.0
// ============================================================================
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int                          N_IN      = 3,
  parameter int                          N_OUT     = 1,
  parameter logic [(2**N_IN)*N_OUT-1:0]  EXP_TABLE = 8'b1110_1000,
  parameter int                          SETTLE    = 1,
  parameter int                          ERR_W     = 8
) (
  input wire logic            clk,
  input wire logic            rst_n,
  tt_sweep_checker_if.master  bus
);

  localparam int                   SW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]        c_settle  = SW'(SETTLE);
  localparam state_t               c_first   = (SETTLE == 0) ? ST_CHECK : ST_WAIT;
  localparam logic [MAX_TBL_W-1:0] c_tbl     = MAX_TBL_W'(EXP_TABLE);

  state_t           state_q,  state_d;
  logic [N_IN-1:0]  stim_q,   stim_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             cont_q,   cont_d;
  logic             pass_q,   pass_d;
  logic [15:0]      sweep_q,  sweep_d;

  logic             w_accept;
  logic             w_clr;
  logic             w_cmp_en;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_cnt;

  assign w_accept   = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign w_clr      = w_accept || ((state_q == ST_DONE) && cont_q && !bus.abort);
  assign w_cmp_en   = (state_q == ST_CHECK) && !bus.abort;
  assign w_mismatch = MAX_OUT_W'(bus.resp_i) != exp_resp(c_tbl, 32'(stim_q), N_OUT);

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    cont_d   = cont_q;
    pass_d   = pass_q;
    sweep_d  = sweep_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          stim_d   = '0;
          sweep_d  = '0;
          pass_d   = 1'b0;
          cont_d   = bus.continuous;
          settle_d = c_settle;
          state_d  = c_first;
        end
        ST_WAIT: begin
          settle_d = settle_q - SW'(1);
          if (settle_q <= SW'(1)) state_d = ST_CHECK;
        end
        ST_CHECK: if (&stim_q) begin
          state_d = ST_DONE;
          sweep_d = sweep_q + 16'd1;
        end else begin
          stim_d   = stim_q + N_IN'(1);
          settle_d = c_settle;
          state_d  = c_first;
        end
        ST_DONE: begin
          pass_d = (w_err_cnt == '0);
          if (cont_q) begin
            stim_d   = '0;
            settle_d = c_settle;
            state_d  = c_first;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      stim_q   <= '0;
      settle_q <= '0;
      cont_q   <= 1'b0;
      pass_q   <= 1'b0;
      sweep_q  <= '0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      cont_q   <= cont_d;
      pass_q   <= pass_d;
      sweep_q  <= sweep_d;
    end
  end

  tt_err_tracker #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ERR_W (ERR_W)
  ) u_err (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (w_clr),
    .cmp_en_i     (w_cmp_en),
    .mismatch_i   (w_mismatch),
    .vec_i        (stim_q),
    .resp_i       (bus.resp_i),
    .err_cnt_o    (w_err_cnt),
    .fail_valid_o (bus.fail_valid),
    .fail_vec_o   (bus.fail_vec),
    .fail_resp_o  (bus.fail_resp)
  );

  // pass is live during the DONE cycle, then held until the next start.
  assign bus.stim_o    = stim_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = (state_q == ST_DONE) ? (w_err_cnt == '0) : pass_q;
  assign bus.err_cnt   = w_err_cnt;
  assign bus.sweep_cnt = sweep_q;

endmodule
`default_nettype wire
